// File: rtl/rf_pkg.sv
// Shared constants for the integer register file and its users in the core.
//   REG_ZERO       : hard-wired zero register index
//   REG_SP         : stack-pointer register index
//   SP_RESET_VAL   : value loaded into the stack pointer on reset
//   DEFAULT_*      : width defaults used across the core
package rf_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 2;

  localparam logic [31:0] SP_RESET_VAL = 32'h7fffefe4;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Pending-write (busy) tracker for the register file.
//   clk, rst              : clock, synchronous active-high reset
//   rd_addr / rd_busy     : per read port, busy unless resolved by this cycle's write
//   we, wa                : writeback enable / address (clears busy)
//   issue_valid, issue_rd : destination reservation request (sets busy)
//   issue_ready           : reservation accepted this cycle (combinational)
//   flush                 : clear every busy bit, drop concurrent issue
//   busy_cnt              : registered count of busy registers
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic                     issue_ready,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clr_en;
  logic             set_en;

  // A write in flight resolves the hazard it targets, so it unblocks readers and WAW issue.
  always_comb begin
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]] &&
                   !(we && (wa == rd_addr[k*ADDR_W +: ADDR_W]));
    end
  end

  assign issue_ready = !busy[issue_rd] || (we && (wa == issue_rd)) ||
                       (issue_rd == ADDR_W'(REG_ZERO));

  assign clr_en = we && (wa != ADDR_W'(REG_ZERO));
  assign set_en = issue_valid && issue_ready && (issue_rd != ADDR_W'(REG_ZERO));

  // Clear before set so a same-register write+issue leaves the bit set.
  // Counter tracks popcount: only a clear of a set bit decrements, and an
  // accepted issue always lands on a bit that is clear after the write.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = busy_cnt;
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      if (clr_en) busy_nxt[wa] = 1'b0;
      if (set_en) busy_nxt[issue_rd] = 1'b1;
      cnt_nxt = busy_cnt + CNT_W'(set_en) - CNT_W'(clr_en && busy[wa]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule : rf_scoreboard

// File: rtl/register_file_sb.sv
// Scoreboarded register file: NUM_RD async read ports, one sync write port,
// optional write-to-read bypass, busy tracking, flush and a debug read port.
//   clk, rst              : clock, synchronous active-high reset
//   rd_addr/rd_data       : packed read ports, port k at [k*W +: W]
//   rd_busy               : per-port pending-write indication
//   we, wa, wd            : writeback port
//   issue_valid/issue_rd  : destination reservation; issue_ready accepts it
//   flush                 : clear all busy bits (data untouched)
//   busy_cnt              : number of busy registers
//   dbg_addr/dbg_data     : raw debug read, never bypassed
module register_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned       NUM_RD    = 2,
  parameter int unsigned       SP_IDX    = REG_SP,
  parameter logic [DATA_W-1:0] SP_RESET  = DATA_W'(SP_RESET_VAL),
  parameter bit                BYPASS_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic                     issue_ready,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Storage; x0 is never written so it holds its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (we && (wa != ADDR_W'(REG_ZERO))) begin
      regs[wa] <= wd;
    end
  end

  // Read muxes with same-cycle forwarding of the writeback value.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      if (a == ADDR_W'(REG_ZERO)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (BYPASS_EN && we && (wa == a)) begin
        rd_data[k*DATA_W +: DATA_W] = wd;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs[a];
      end
    end
  end

  assign dbg_data = (dbg_addr == ADDR_W'(REG_ZERO)) ? '0 : regs[dbg_addr];

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .we          (we),
    .wa          (wa),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .busy_cnt    (busy_cnt)
  );

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb with a background busy-count model.
module tb_register_file_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we = 1'b0;
  logic [ADDR_W-1:0]        wa = '0;
  logic [DATA_W-1:0]        wd = '0;
  logic                     issue_valid = 1'b0;
  logic [ADDR_W-1:0]        issue_rd = '0;
  logic                     issue_ready;
  logic                     flush = 1'b0;
  logic [ADDR_W:0]          busy_cnt;
  logic [ADDR_W-1:0]        dbg_addr = '0;
  logic [DATA_W-1:0]        dbg_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit pop_chk_on = 1'b0;
  logic [31:0] model_busy = '0;

  register_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .busy_cnt    (busy_cnt),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent busy-bit model built from the stimulus.
  always @(posedge clk) begin
    logic [31:0] nb;
    logic        rdy;
    nb  = model_busy;
    rdy = !model_busy[issue_rd] || (we && wa == issue_rd) || issue_rd == 0;
    if (rst || flush) begin
      nb = '0;
    end else begin
      if (we && wa != 0) nb[wa] = 1'b0;
      if (issue_valid && rdy && issue_rd != 0) nb[issue_rd] = 1'b1;
    end
    model_busy <= nb;
  end

  always @(negedge clk) begin
    if (pop_chk_on) chk("busy_cnt_popcount", 64'(busy_cnt), 64'($countones(model_busy)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    issue_valid = 1'b0; issue_rd = '0;
    flush = 1'b0; rst = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  initial begin
    // Reset
    tick(); tick();
    idle();
    pop_chk_on = 1'b1;
    set_rd(2, 5); issue_rd = 5; dbg_addr = 2; #1;
    chk("rst_x2", 64'(rd_data[31:0]), 64'h7fffefe4);
    chk("rst_x5", 64'(rd_data[63:32]), 64'h0);
    chk("rst_cnt", 64'(busy_cnt), 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h1);
    chk("rst_dbg_x2", 64'(dbg_data), 64'h7fffefe4);

    // Issue x5, then write it back
    issue_valid = 1'b1; issue_rd = 5; #1;
    chk("iss5_ready", 64'(issue_ready), 64'h1);
    tick(); idle();
    set_rd(5, 0); #1;
    chk("x5_busy", 64'(rd_busy[0]), 64'h1);
    chk("x5_cnt1", 64'(busy_cnt), 64'h1);
    we = 1'b1; wa = 5; wd = 32'hDEADBEEF; set_rd(5, 5); dbg_addr = 5; #1;
    chk("byp_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("byp_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    chk("byp_busy", 64'(rd_busy), 64'h0);
    chk("dbg_nobyp", 64'(dbg_data), 64'h0);
    tick(); idle(); #1;
    chk("wb_cnt0", 64'(busy_cnt), 64'h0);
    chk("wb_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("wb_dbg", 64'(dbg_data), 64'hDEADBEEF);

    // WAW stall on x7
    issue_valid = 1'b1; issue_rd = 7;
    tick(); #1;
    chk("waw_ready0", 64'(issue_ready), 64'h0);
    tick(); idle(); #1;
    chk("waw_cnt", 64'(busy_cnt), 64'h1);
    we = 1'b1; wa = 7; wd = 32'h77; issue_valid = 1'b1; issue_rd = 7; set_rd(7, 0); #1;
    chk("waw_ready1", 64'(issue_ready), 64'h1);
    chk("waw_rdbusy", 64'(rd_busy[0]), 64'h0);
    tick(); idle(); #1;
    chk("waw_still_busy", 64'(rd_busy[0]), 64'h1);
    chk("waw_cnt1", 64'(busy_cnt), 64'h1);
    chk("waw_data", 64'(rd_data[31:0]), 64'h77);

    // x0: write and issue are both no-ops
    we = 1'b1; wa = 0; wd = 32'h1234; issue_valid = 1'b1; issue_rd = 0; set_rd(0, 0); #1;
    chk("x0_byp", 64'(rd_data[31:0]), 64'h0);
    chk("x0_ready", 64'(issue_ready), 64'h1);
    tick(); idle(); dbg_addr = 0; #1;
    chk("x0_data", 64'(rd_data[31:0]), 64'h0);
    chk("x0_busy", 64'(rd_busy[0]), 64'h0);
    chk("x0_cnt", 64'(busy_cnt), 64'h1);
    chk("x0_dbg", 64'(dbg_data), 64'h0);
    we = 1'b1; wa = 7; wd = 32'h78;
    tick(); idle(); #1;
    chk("x7_clr_cnt", 64'(busy_cnt), 64'h0);

    // Flush with concurrent issue and write
    issue_valid = 1'b1; issue_rd = 3; tick();
    issue_rd = 4; tick();
    issue_rd = 9; tick(); idle(); #1;
    chk("pre_flush_cnt", 64'(busy_cnt), 64'h3);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 10; we = 1'b1; wa = 3; wd = 32'h55;
    tick(); idle(); set_rd(3, 10); #1;
    chk("flush_cnt", 64'(busy_cnt), 64'h0);
    chk("flush_x10", 64'(rd_busy[1]), 64'h0);
    chk("flush_x3_busy", 64'(rd_busy[0]), 64'h0);
    chk("flush_x3_data", 64'(rd_data[31:0]), 64'h55);

    // Reset mid-operation
    issue_valid = 1'b1; issue_rd = 8; tick(); idle(); #1;
    chk("pre_rst_cnt", 64'(busy_cnt), 64'h1);
    rst = 1'b1; we = 1'b1; wa = 2; wd = 32'h0; issue_valid = 1'b1; issue_rd = 6;
    tick(); idle(); set_rd(2, 6); dbg_addr = 5; #1;
    chk("mrst_x2", 64'(rd_data[31:0]), 64'h7fffefe4);
    chk("mrst_x6_busy", 64'(rd_busy[1]), 64'h0);
    chk("mrst_cnt", 64'(busy_cnt), 64'h0);
    chk("mrst_x5", 64'(dbg_data), 64'h0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_register_file_sb
